// File: rtl/npc_lsu_if.sv
// Interfaces for the LSU: the execute/write-back handshake and the data-memory bus.
// "master" is the side that issues the request; "slave" is the side that answers it.

interface npc_lsu_exu_if;
  logic        in_valid;
  logic        in_ready;
  logic        MemRd;
  logic        MemWr;
  logic [2:0]  MemOp;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_err;

  modport master (
    output in_valid, MemRd, MemWr, MemOp, addr, wdata, out_ready,
    input  in_ready, out_valid, out_rdata, out_err
  );

  modport slave (
    input  in_valid, MemRd, MemWr, MemOp, addr, wdata, out_ready,
    output in_ready, out_valid, out_rdata, out_err
  );
endinterface

interface npc_lsu_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/npc_lsu.sv
// Load/store unit: one outstanding request on a req/gnt/rvalid data bus, returning
// an aligned and extended load result (or an error) through a valid/ready handshake.

module npc_lsu #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic          clk,
  input  logic          rst,
  npc_lsu_exu_if.slave  exu,
  npc_lsu_mem_if.master mem
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  // Bad combination, illegal MemOp for the direction, or misaligned address.
  function automatic logic req_error(input logic rd, input logic wr,
                                     input logic [2:0] op, input logic [31:0] a);
    logic legal;
    logic misal;
    if (rd && wr) return 1'b1;
    if (!rd && !wr) return 1'b0;
    if (rd) legal = op inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else    legal = op inside {3'b000, 3'b001, 3'b010};
    misal = ((op[1:0] == 2'b01) && a[0]) || ((op[1:0] == 2'b10) && (a[1:0] != 2'b00));
    return !legal || misal;
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] op, input logic [1:0] off);
    case (op[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] w);
    case (op[1:0])
      2'b00:   return {4{w[7:0]}};
      2'b01:   return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  // Pick the addressed lane and extend it; op[2] selects zero-extension.
  function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] off,
                                              input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (op)
      3'b000:  r = 32'(b);
      3'b100:  r = {24'd0, b};
      3'b001:  r = 32'(h);
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             acc_err;
  logic             acc_nop;
  logic             cnt_hit;

  logic [31:0]      addr_p0;
  logic [31:0]      wdata_p0;
  logic [2:0]       op_p0;
  logic             rd_p0;
  logic             wr_p0;

  logic [31:0]      rdata_p1;
  logic             err_p1;

  assign accept  = (state_q == S_IDLE) && exu.in_valid;
  assign acc_err = req_error(exu.MemRd, exu.MemWr, exu.MemOp, exu.addr);
  assign acc_nop = !exu.MemRd && !exu.MemWr;
  assign cnt_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (acc_err || acc_nop) ? S_RESP : S_REQ;
      S_REQ:  if (mem.mem_gnt) state_d = wr_p0 ? S_RESP : S_WAIT;
      S_WAIT: if (mem.mem_rvalid || cnt_hit) state_d = S_RESP;
      S_RESP: if (exu.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are gated by state so the data registers need no reset.
  always_comb begin
    exu.in_ready  = (state_q == S_IDLE);
    exu.out_valid = (state_q == S_RESP);
    exu.out_rdata = (state_q == S_RESP) ? rdata_p1 : 32'd0;
    exu.out_err   = (state_q == S_RESP) && err_p1;
    mem.mem_req   = (state_q == S_REQ);
    mem.mem_we    = (state_q == S_REQ) && wr_p0;
    mem.mem_addr  = (state_q == S_REQ) ? {addr_p0[31:2], 2'b00} : 32'd0;
    mem.mem_wdata = ((state_q == S_REQ) && wr_p0) ? store_data(op_p0, wdata_p0) : 32'd0;
    mem.mem_wmask = ((state_q == S_REQ) && wr_p0) ? store_mask(op_p0, addr_p0[1:0]) : 4'd0;
  end

  always_ff @(posedge clk) begin
    if (rst)                    cnt_q <= '0;
    else if (state_q == S_REQ)  cnt_q <= '0;
    else if (state_q == S_WAIT) cnt_q <= cnt_q + 1'b1;
  end

  // Stage p0: request captured at acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0  <= exu.addr;
      wdata_p0 <= exu.wdata;
      op_p0    <= exu.MemOp;
      rd_p0    <= exu.MemRd;
      wr_p0    <= exu.MemWr;
    end
  end

  // Stage p1: response word, preset at acceptance and overwritten by load completion.
  always_ff @(posedge clk) begin
    if (accept) begin
      rdata_p1 <= 32'd0;
      err_p1   <= acc_err;
    end else if (state_q == S_WAIT) begin
      if (mem.mem_rvalid) begin
        rdata_p1 <= load_extend(op_p0, addr_p0[1:0], mem.mem_rdata);
        err_p1   <= 1'b0;
      end else if (cnt_hit) begin
        rdata_p1 <= 32'd0;
        err_p1   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_npc_lsu.sv
// Bench for npc_lsu: a vector table of loads/stores/errors with a response scoreboard,
// followed by hand-written timeout, reset and stray-bus-event sequences.

module tb_npc_lsu;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  npc_lsu_exu_if exu ();
  npc_lsu_mem_if mem ();

  npc_lsu #(.TIMEOUT(TO), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .exu (exu),
    .mem (mem)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        bus;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mask;
    logic [31:0] out;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] op,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic [31:0] maddr,
                              input logic [31:0] mwdata, input logic [3:0] mask,
                              input logic [31:0] out, input logic err);
    vec_t v;
    v.rd = rd; v.wr = wr; v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.bus = (rd ^ wr) && !err;
    v.maddr = maddr; v.mwdata = mwdata; v.mask = mask; v.out = out; v.err = err;
    return v;
  endfunction

  task automatic drive_req(input logic rd, input logic wr, input logic [2:0] op,
                           input logic [31:0] addr, input logic [31:0] wdata);
    exu.in_valid = 1'b1;
    exu.MemRd    = rd;
    exu.MemWr    = wr;
    exu.MemOp    = op;
    exu.addr     = addr;
    exu.wdata    = wdata;
  endtask

  task automatic clear_req();
    exu.in_valid = 1'b0;
    exu.MemRd    = 1'b0;
    exu.MemWr    = 1'b0;
  endtask

  // Expects out_valid now; holds out_ready low rdy_dly cycles, then pops the scoreboard.
  task automatic finish_resp(input int rdy_dly);
    exp_t e;
    int   n;
    check("out_valid_latency", exu.out_valid, 1'b1);
    n = 0;
    while (!exu.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < rdy_dly; i++) begin
      check("hold_valid", exu.out_valid, 1'b1);
      check("hold_rdata", exu.out_rdata, sb[0].rdata);
      check("hold_err", exu.out_err, sb[0].err);
      check("in_ready_resp", exu.in_ready, 1'b0);
      @(negedge clk);
    end
    e = sb.pop_front();
    check("out_rdata", exu.out_rdata, e.rdata);
    check("out_err", exu.out_err, e.err);
    check("in_ready_resp", exu.in_ready, 1'b0);
    exu.out_ready = 1'b1;
    @(negedge clk);
    exu.out_ready = 1'b0;
    check("out_valid_drop", exu.out_valid, 1'b0);
    check("in_ready_back", exu.in_ready, 1'b1);
  endtask

  task automatic run_txn(input vec_t v, input int gnt_dly, input int rv_dly, input int rdy_dly);
    exp_t e;
    @(negedge clk);
    check("in_ready_idle", exu.in_ready, 1'b1);
    drive_req(v.rd, v.wr, v.op, v.addr, v.wdata);
    e.rdata = v.out;
    e.err   = v.err;
    sb.push_back(e);
    @(negedge clk);
    clear_req();
    check("in_ready_busy", exu.in_ready, 1'b0);
    if (v.bus) begin
      for (int i = 0; i <= gnt_dly; i++) begin
        check("mem_req", mem.mem_req, 1'b1);
        check("mem_addr", mem.mem_addr, v.maddr);
        check("mem_we", mem.mem_we, v.wr);
        check("mem_wmask", mem.mem_wmask, v.mask);
        if (v.wr) check("mem_wdata", mem.mem_wdata, v.mwdata);
        check("out_valid_req", exu.out_valid, 1'b0);
        if (i == gnt_dly) mem.mem_gnt = 1'b1;
        @(negedge clk);
        mem.mem_gnt = 1'b0;
      end
      if (v.rd) begin
        for (int i = 0; i < rv_dly; i++) begin
          check("mem_req_wait", mem.mem_req, 1'b0);
          check("out_valid_wait", exu.out_valid, 1'b0);
          @(negedge clk);
        end
        check("mem_req_wait", mem.mem_req, 1'b0);
        mem.mem_rvalid = 1'b1;
        mem.mem_rdata  = v.rdata;
        @(negedge clk);
        mem.mem_rvalid = 1'b0;
        mem.mem_rdata  = 32'd0;
      end
    end else begin
      check("mem_req_none", mem.mem_req, 1'b0);
    end
    finish_resp(rdy_dly);
  endtask

  initial begin
    exp_t e;
    int   n;
    clear_req();
    exu.MemOp = 3'b000; exu.addr = 32'd0; exu.wdata = 32'd0; exu.out_ready = 1'b0;
    mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = 32'd0;

    //      rd wr op      addr          wdata         rdata         maddr         mwdata        mask     out           err
    vecs.push_back(mk(1, 0, 3'b010, 32'h80000004, 32'h0,        32'hDEADBEEF, 32'h80000004, 32'h0,        4'b0000, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 0, 3'b000, 32'h80000003, 32'h0,        32'h80FF7F01, 32'h80000000, 32'h0,        4'b0000, 32'hFFFFFF80, 0));
    vecs.push_back(mk(1, 0, 3'b100, 32'h80000003, 32'h0,        32'h80FF7F01, 32'h80000000, 32'h0,        4'b0000, 32'h00000080, 0));
    vecs.push_back(mk(1, 0, 3'b001, 32'h80000002, 32'h0,        32'h80FF7F01, 32'h80000000, 32'h0,        4'b0000, 32'hFFFF80FF, 0));
    vecs.push_back(mk(1, 0, 3'b101, 32'h80000002, 32'h0,        32'h80FF7F01, 32'h80000000, 32'h0,        4'b0000, 32'h000080FF, 0));
    vecs.push_back(mk(1, 0, 3'b000, 32'h80000001, 32'h0,        32'h80FF7F01, 32'h80000000, 32'h0,        4'b0000, 32'h0000007F, 0));
    vecs.push_back(mk(1, 0, 3'b001, 32'h80000000, 32'h0,        32'h80FF7F01, 32'h80000000, 32'h0,        4'b0000, 32'h00007F01, 0));
    vecs.push_back(mk(1, 0, 3'b100, 32'h80000002, 32'h0,        32'h80FF7F01, 32'h80000000, 32'h0,        4'b0000, 32'h000000FF, 0));
    vecs.push_back(mk(0, 1, 3'b000, 32'h80000001, 32'h123456AB, 32'h0,        32'h80000000, 32'hABABABAB, 4'b0010, 32'h0,        0));
    vecs.push_back(mk(0, 1, 3'b001, 32'h80000002, 32'h123456AB, 32'h0,        32'h80000000, 32'h56AB56AB, 4'b1100, 32'h0,        0));
    vecs.push_back(mk(0, 1, 3'b010, 32'h80000008, 32'hCAFEF00D, 32'h0,        32'h80000008, 32'hCAFEF00D, 4'b1111, 32'h0,        0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h80000002, 32'h0,        32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        1));
    vecs.push_back(mk(0, 1, 3'b001, 32'h80000001, 32'h0,        32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        1));
    vecs.push_back(mk(1, 0, 3'b011, 32'h80000000, 32'h0,        32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        1));
    vecs.push_back(mk(1, 1, 3'b010, 32'h80000000, 32'h0,        32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        1));
    vecs.push_back(mk(0, 1, 3'b100, 32'h80000000, 32'h0,        32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        1));
    vecs.push_back(mk(0, 0, 3'b010, 32'h80000003, 32'h0,        32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        0));

    repeat (3) @(negedge clk);
    check("rst_in_ready", exu.in_ready, 1'b1);
    check("rst_out_valid", exu.out_valid, 1'b0);
    check("rst_out_rdata", exu.out_rdata, 32'd0);
    check("rst_out_err", exu.out_err, 1'b0);
    check("rst_mem_req", mem.mem_req, 1'b0);
    check("rst_mem_addr", mem.mem_addr, 32'd0);
    check("rst_mem_wmask", mem.mem_wmask, 4'd0);
    rst = 1'b0;

    // Zero-wait table pass, then a pass with assorted bus and write-back delays.
    foreach (vecs[i]) run_txn(vecs[i], 0, 0, 0);
    foreach (vecs[i]) run_txn(vecs[i], i % 3, i % 3, i % 2);

    // Grant delayed 3 cycles, write-back stalled 4 cycles.
    run_txn(vecs[0], 3, 1, 4);
    run_txn(vecs[8], 3, 0, 4);

    // Load with no rvalid: timeout error.
    @(negedge clk);
    drive_req(1'b1, 1'b0, 3'b010, 32'h80000010, 32'h0);
    e.rdata = 32'd0; e.err = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    clear_req();
    check("to_mem_req", mem.mem_req, 1'b1);
    mem.mem_gnt = 1'b1;
    @(negedge clk);
    mem.mem_gnt = 1'b0;
    n = 0;
    while (!exu.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("to_elapsed_min", 32'(n >= TO), 32'd1);
    check("to_elapsed_max", 32'(n <= TO + 1), 32'd1);
    finish_resp(0);

    // Reset while waiting for load data; a stray rvalid afterwards is ignored.
    @(negedge clk);
    drive_req(1'b1, 1'b0, 3'b010, 32'h80000020, 32'h0);
    @(negedge clk);
    clear_req();
    mem.mem_gnt = 1'b1;
    @(negedge clk);
    mem.mem_gnt = 1'b0;
    check("wait_in_ready", exu.in_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstw_in_ready", exu.in_ready, 1'b1);
    check("rstw_mem_req", mem.mem_req, 1'b0);
    mem.mem_rvalid = 1'b1;
    mem.mem_rdata  = 32'h55AA55AA;
    @(negedge clk);
    mem.mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stray_rvalid_out_valid", exu.out_valid, 1'b0);
      check("stray_rvalid_in_ready", exu.in_ready, 1'b1);
      @(negedge clk);
    end

    // Reset while requesting: mem_req drops on the next cycle; a stray grant is ignored.
    drive_req(1'b0, 1'b1, 3'b010, 32'h80000030, 32'h11223344);
    @(negedge clk);
    clear_req();
    check("rstr_mem_req_hi", mem.mem_req, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstr_mem_req_lo", mem.mem_req, 1'b0);
    mem.mem_gnt = 1'b1;
    @(negedge clk);
    mem.mem_gnt = 1'b0;
    check("stray_gnt_mem_req", mem.mem_req, 1'b0);
    check("stray_gnt_out_valid", exu.out_valid, 1'b0);
    check("stray_gnt_in_ready", exu.in_ready, 1'b1);

    // The LSU still works normally afterwards.
    run_txn(vecs[1], 1, 2, 1);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
